// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, default baud constants and parity helper
//
// Purpose: common definitions for the UART receiver and transmitter.
//   rx_state_t      receiver FSM states
//   parity_bit()    parity bit a transmitter appends to a data word
//   DEFAULT_*       100 MHz / 9600 baud defaults
package uart_pkg;

    localparam int DEFAULT_CLK_HZ       = 100_000_000;
    localparam int DEFAULT_BAUD         = 9600;
    localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_HZ / DEFAULT_BAUD;
    localparam int DEFAULT_SYNC_STAGES  = 2;

    // Widest data word the parity helper accepts; narrower words are
    // zero-extended, which leaves their XOR unchanged.
    localparam int MAX_DATA_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and parallel result bundle of the UART receiver
//
// Purpose: groups the receiver's line inputs and frame results.
//   rx_in, parity_enable                        driven by master (board/user side)
//   rx_data, rx_valid, parity_err, frame_err,
//   busy                                        driven by slave (uart_rx)
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic                 parity_enable;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_in,
        output parity_enable,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_in,
        input  parity_enable,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchronizer for the asynchronous rx line
//
// Purpose: brings rx into the clk domain; flops reset to 1 (idle line).
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   i_async   raw asynchronous input
//   o_sync    synchronized output, SYNC_STAGES cycles later
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start/data/parity/stop framing with mid-bit sampling
//
// Purpose: receives 1 start bit, DATA_BITS data bits LSB-first, an optional
// parity bit and 1 stop bit; emits the word with a one-cycle rx_valid strobe
// and per-frame parity/framing error flags.
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset
//   bus     uart_rx_if slave: rx_in, parity_enable in; rx_data, rx_valid,
//           parity_err, frame_err, busy out (all outputs registered)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // Counter reload values: a half bit to reach mid start bit, then whole
    // bits so every later sample lands mid-bit as well.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    logic                     w_rx_s;
    logic [MAX_DATA_BITS-1:0] w_shift_ext;
    logic                     w_par_ref;

    rx_state_t                r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [DATA_BITS-1:0]     r_shift;
    logic                     r_par_en;
    logic                     r_par_err_int;
    logic [DATA_BITS-1:0]     r_rx_data;
    logic                     r_rx_valid;
    logic                     r_parity_err;
    logic                     r_frame_err;
    logic                     r_busy;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.rx_in),
        .o_sync  (w_rx_s)
    );

    assign w_shift_ext = MAX_DATA_BITS'(r_shift);
    assign w_par_ref   = parity_bit(w_shift_ext, ODD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_par_en      <= 1'b0;
            r_par_err_int <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt         <= HALF_LOAD;
                        r_par_en      <= bus.parity_enable;
                        r_par_err_int <= 1'b0;
                        r_state       <= START;
                        r_busy        <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == '0) begin
                        if (!w_rx_s) begin
                            r_cnt   <= FULL_LOAD;
                            r_idx   <= '0;
                            r_state <= DATA;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= FULL_LOAD;
                        // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_idx   <= r_idx + IDX_W'(1);
                        if (r_idx == LAST_IDX) begin
                            r_state <= r_par_en ? PARITY : STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (r_cnt == '0) begin
                        r_cnt         <= FULL_LOAD;
                        r_par_err_int <= (w_rx_s != w_par_ref);
                        r_state       <= STOP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_cnt == '0) begin
                        r_rx_data    <= r_shift;
                        r_rx_valid   <= 1'b1;
                        r_frame_err  <= ~w_rx_s;
                        r_parity_err <= r_par_en & r_par_err_int;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    // A held-low (break) line must not be taken as a new start bit.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = r_busy;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART link; the receive-side counterpart of the team's transmitter.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB-first, optional even/odd parity bit, 1 stop bit (1).
- Samples the asynchronous rx line at mid-bit and delivers one parallel word per frame with a single-cycle valid strobe and per-frame error flags.
- Sits between the board RX pin and user logic (LEDs/registers).

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per bit (100 MHz / 9600 baud); must be >= 4.
- DATA_BITS, 8, data bits per frame.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
- SYNC_STAGES, 2, flip-flop stages in the rx input synchronizer (>= 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_in  input  1  raw serial line; idles high.
- parity_enable  input  1  1 = frame carries a parity bit.
- rx_data  output  DATA_BITS  last received word.
- rx_valid  output  1  one-cycle strobe when a frame completes.
- parity_err  output  1  parity mismatch on the frame; valid only with rx_valid.
- frame_err  output  1  stop bit sampled 0; valid only with rx_valid.
- busy  output  1  high from start detection until return to IDLE.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchronizer flops set to 1 (line idle). Reset takes effect mid-frame immediately, and the partial frame is discarded.
- rx_in passes through the SYNC_STAGES synchronizer; all logic uses the synchronized bit rx_s.
- Bit counter: width $clog2(CLKS_PER_BIT). Bit index counter: width $clog2(DATA_BITS+1).
- IDLE: on rx_s == 0, load the counter, latch parity_enable into a frame-local flag, go to START, assert busy. Changes to parity_enable during a frame are ignored.
- START: wait CLKS_PER_BIT/2 cycles (integer division), then resample.
  - rx_s == 0: go to DATA with the counter reloaded.
  - rx_s == 1: glitch; return to IDLE with no strobe.
- DATA: sample rx_s every CLKS_PER_BIT cycles and shift it into the MSB of a DATA_BITS shift register (LSB-first reception). After DATA_BITS samples, go to PARITY if the latched flag is set, else STOP.
- PARITY: sample one bit; parity_err_int = (^data ^ sampled_bit) != PARITY_ODD.
- STOP: sample one bit, then:
  - rx_data <= shift register; rx_valid = 1 for exactly one cycle on the cycle after the stop sample.
  - frame_err = ~stop_sample; parity_err = parity_err_int (forced 0 if parity is disabled).
  - If stop_sample == 1, go to IDLE. Otherwise go to WAIT_IDLE.
- WAIT_IDLE (break/framing recovery): remain until rx_s == 1, then go to IDLE. No new start is detected while the line is held low.
- busy = (state != IDLE).
- Error flags hold their value until the next rx_valid. rx_data holds until the next completed frame.
- Latency: rx_valid occurs SYNC_STAGES + (CLKS_PER_BIT/2) + (nbits+1)·CLKS_PER_BIT + 1 cycles after the rx_in falling edge, where nbits = DATA_BITS + parity flag.
- Back-to-back frames: a falling edge on the cycle IDLE is re-entered is detected; there is no dead cycle requirement beyond the stop bit.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE};
  - function for the parity calculation, shared with the transmitter;
  - default baud constants.
- One sub-module: uart_sync (parameterized SYNC_STAGES synchronizer with reset value 1).
- Counters and the FSM live in uart_rx.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
- Frame 0xA5, parity off, stop=1 -> rx_valid pulses once, rx_data=0xA5, both errors 0, at the latency given by the formula.
- Frame 0x3C, parity on, even parity bit=0 -> rx_data=0x3C, parity_err=0. Repeat with parity bit=1 -> parity_err=1, rx_data=0x3C.
- Frame 0x55 with stop bit driven 0 and line held low for 40 cycles -> frame_err=1. No second rx_valid until the line returns high and a new frame 0x12 is received correctly.
- 5-cycle low glitch on an idle line -> no rx_valid, busy returns to 0 after ~8 cycles.
- Assert reset mid-DATA of frame 0xFF -> outputs 0, no strobe. The next frame 0x81 is received correctly.
- Two back-to-back frames 0x01, 0x80 with no idle gap -> two rx_valid strobes exactly 160 cycles apart, with the correct data each time.
